// File: rtl/imem_loader.sv
// Instruction memory loader: takes a byte stream (count byte followed by
// little-endian words), fills a DEPTH x N memory and exposes a zero-latency fetch port.
module imem_loader #(
  parameter int N     = 32,
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         start,
  input  logic [5:0]   addr,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [6:0]   words_loaded
);

  localparam int NB = N / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST_LANE = BW'(NB - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  state_t          state_q, state_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [BW-1:0]   byte_idx_q, byte_idx_d;
  logic [6:0]      word_idx_q, word_idx_d;
  logic [6:0]      words_q, words_d;
  logic [N-1:0]    asm_q, asm_d;
  logic            we;
  logic [N-1:0]    mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      words_q    <= '0;
      asm_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      words_q    <= words_d;
      asm_q      <= asm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    words_d    = words_q;
    asm_d      = asm_q;
    we         = 1'b0;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_data != 8'd0 && in_data <= 8'd64) begin
            state_d    = LOAD;
            cnt_d      = in_data[6:0];
            byte_idx_d = '0;
            word_idx_d = '0;
            words_d    = '0;
          end else begin
            state_d = ERR;
          end
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          asm_d[int'(byte_idx_q) * 8 +: 8] = in_data;
          if (byte_idx_q == LAST_LANE) begin
            // The completed word (including this byte) is written on this same edge.
            we         = 1'b1;
            byte_idx_d = '0;
            word_idx_d = word_idx_q + 7'd1;
            words_d    = (words_q < cnt_q) ? words_q + 7'd1 : words_q;
            if (word_idx_q == cnt_q - 7'd1) state_d = DONE;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = IDLE;
          words_d = '0;
        end
      end
      ERR: begin
        err = 1'b1;
        if (start) begin
          state_d = IDLE;
          words_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory contents survive re-arming; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[word_idx_q[5:0]] <= asm_d;
    end
  end

  assign q            = mem_q[addr];
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: stream-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_imem_loader;
  localparam int N  = 32;
  localparam int NB = N / 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic         start;
  logic [5:0]   addr;
  logic [N-1:0] q;
  logic         busy, done, err;
  logic [6:0]   words_loaded;

  always #5 clk = ~clk;

  imem_loader #(.N(N), .DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .start(start), .addr(addr), .q(q),
    .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 loading, 2 done, 3 error.
  int           m_mode, m_c, m_bytes, m_words;
  logic [N-1:0] m_asm;
  logic [N-1:0] exp_mem [64];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_c = 0; m_bytes = 0; m_words = 0; m_asm = '0;
      for (int i = 0; i < 64; i++) exp_mem[i] = '0;
    end else begin
      case (m_mode)
        0: if (in_valid) begin
          if (in_data >= 8'd1 && in_data <= 8'd64) begin
            m_c = int'(in_data); m_bytes = 0; m_words = 0; m_mode = 1;
          end else m_mode = 3;
        end
        1: if (in_valid) begin
          int lane;
          lane = m_bytes % NB;
          m_asm[lane*8 +: 8] = in_data;
          if (lane == NB - 1) begin
            exp_mem[m_bytes / NB] = m_asm;
            m_words++;
            if (m_words == m_c) m_mode = 2;
          end
          m_bytes++;
        end
        default: if (start) begin
          m_mode = 0; m_words = 0;
        end
      endcase
    end
  end

  bit run_cmp = 1'b0;
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("in_ready", 64'(in_ready), 64'(m_mode < 2));
      chk("busy", 64'(busy), 64'(m_mode == 1));
      chk("done", 64'(done), 64'(m_mode == 2));
      chk("err", 64'(err), 64'(m_mode == 3));
      chk("words_loaded", 64'(words_loaded), 64'(m_words));
      chk("q", 64'(q), 64'(exp_mem[addr]));
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic put(input logic [7:0] b);
    in_valid = 1'b1; in_data = b; cyc(); in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  logic [7:0] s1 [9] = '{8'h02, 8'h33, 8'h00, 8'h00, 8'h00, 8'h33, 8'h05, 8'ha5, 8'h00};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; start = 1'b0; addr = 6'd0;
    #1 run_cmp = 1'b1;
    #1;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst busy/done/err", 64'({busy, done, err}), 64'd0);
    chk("rst words", 64'(words_loaded), 64'd0);
    addr = 6'd37; #1;
    chk("rst q", 64'(q), 64'd0);
    addr = 6'd0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Basic back-to-back load
    foreach (s1[i]) put(s1[i]);
    chk("basic done", 64'(done), 64'd1);
    chk("basic in_ready", 64'(in_ready), 64'd0);
    chk("basic words", 64'(words_loaded), 64'd2);
    addr = 6'd0; #1; chk("basic mem0", 64'(q), 64'h00000033);
    addr = 6'd1; #1; chk("basic mem1", 64'(q), 64'h00a50533);
    in_valid = 1'b1; in_data = 8'h55; cyc(); cyc(); in_valid = 1'b0;
    chk("done holds", 64'(done), 64'd1);

    // Same stream with a bubble after every byte
    pulse_start();
    chk("rearm idle", 64'({busy, done, err}), 64'd0);
    foreach (s1[i]) begin
      put(s1[i]);
      if (i == 4) chk("gap busy", 64'(busy), 64'd1);
      if (i != 8) begin in_data = 8'hff; cyc(); end
    end
    chk("gap done", 64'(done), 64'd1);
    addr = 6'd0; #1; chk("gap mem0", 64'(q), 64'h00000033);
    addr = 6'd1; #1; chk("gap mem1", 64'(q), 64'h00a50533);

    // Bad counts
    pulse_start();
    put(8'h00);
    chk("cnt0 err", 64'(err), 64'd1);
    chk("cnt0 in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_data = 8'h02; cyc(); cyc(); in_valid = 1'b0;
    chk("err holds", 64'(err), 64'd1);
    pulse_start();
    chk("err rearm", 64'({in_ready, err}), 64'b10);
    put(8'h41);
    chk("cnt41 err", 64'(err), 64'd1);
    pulse_start();

    // Reload one word over a previous two-word image
    put(8'h01); put(8'h63); put(8'h00); put(8'h00);
    addr = 6'd0; in_valid = 1'b1; in_data = 8'h00;
    @(negedge clk);
    chk("same-cycle old q", 64'(q), 64'h00000033);
    @(posedge clk); #1; in_valid = 1'b0;
    chk("reload new q", 64'(q), 64'h00000063);
    chk("reload done", 64'(done), 64'd1);
    chk("reload words", 64'(words_loaded), 64'd1);
    addr = 6'd1; #1; chk("reload mem1 kept", 64'(q), 64'h00a50533);
    cyc();

    // Reset in the middle of a two-word load
    pulse_start();
    put(8'h02); put(8'h11); put(8'h22); put(8'h33); put(8'h44); put(8'h55);
    rst_n = 1'b0;
    for (int a = 0; a < 64; a++) begin
      addr = 6'(a); #1;
      chk("midrst q zero", 64'(q), 64'd0);
    end
    chk("midrst idle", 64'({in_ready, busy, done, err}), 64'b1000);
    cyc();
    rst_n = 1'b1;
    cyc();
    put(8'h01); put(8'h44); put(8'h33); put(8'h22); put(8'h11);
    chk("post-rst done", 64'(done), 64'd1);
    addr = 6'd0; #1; chk("post-rst mem0", 64'(q), 64'h11223344);
    cyc();

    // Full 64-word load; a stray start mid-load must be ignored
    pulse_start();
    put(8'h40);
    for (int k = 0; k < 256; k++) begin
      if (k == 100) start = 1'b1;
      put(8'(k * 7 + 3));
      start = 1'b0;
    end
    chk("full done", 64'(done), 64'd1);
    chk("full words", 64'(words_loaded), 64'd64);
    for (int a = 0; a < 64; a++) begin
      addr = 6'(a); cyc();
    end
    addr = 6'd0;  #1; chk("full mem0", 64'(q), 64'h18110a03);
    addr = 6'd63; #1; chk("full mem63", 64'(q), 64'hfcf5eee7);
    cyc();

    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
